sram_port_arbiter: RTL

- Shares one single-port, byte-lane SRAM macro between two requesters: instruction fetch (I, read-only) and load/store (D, read/write with byte strobes).
- Macro: word-addressed, pipelined read (data valid the cycle after CS), write not pipelined.
- One SRAM access is issued per cycle, chosen by round-robin with a burst limit. Each access returns a response one cycle later, tagged to the port that issued it.
- Sits between the core's fetch/LSU and the SRAM instance.

---
 rtl/sram_port_arbiter_if.sv | 51 +++++
 rtl/sram_port_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - fetch/LSU request ports plus SRAM macro pins for sram_port_arbiter
//
// Purpose: bundles every non-clock signal of the arbiter.
//   slave  modport : the arbiter (takes requests and SRAM read data, drives grants,
//                    responses and SRAM control).
//   master modport : the surroundings (fetch unit, LSU and the SRAM macro).
// Signals:
//   i_req/i_addr            fetch request, word address
//   i_gnt                   fetch request accepted this cycle
//   i_rvalid/i_rdata        fetch read response
//   d_req/d_addr/d_we/d_be/d_wdata  load/store request
//   d_gnt                   load/store request accepted this cycle
//   d_rvalid/d_rdata        load data or write acknowledge
//   sram_cs/sram_addr/sram_wdata/sram_wren  SRAM macro inputs
//   sram_rdata              SRAM macro read data (valid the cycle after sram_cs)
interface sram_port_arbiter_if #(
  parameter int AW = 16
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [31:0]   i_rdata;

  logic          d_req;
  logic [AW-1:0] d_addr;
  logic          d_we;
  logic [3:0]    d_be;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;

  logic          sram_cs;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [3:0]    sram_wren;
  logic [31:0]   sram_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_we, d_be, d_wdata, sram_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           sram_cs, sram_addr, sram_wdata, sram_wren
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_we, d_be, d_wdata, sram_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           sram_cs, sram_addr, sram_wdata, sram_wren
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one single-port byte-lane SRAM between fetch and load/store
//
// Purpose: issues at most one SRAM access per cycle, picked by round-robin with a
// burst limit, and returns each access's response exactly one cycle later on the
// port that issued it.
// Ports:
//   clk_i  system clock, rising edge
//   rst_i  asynchronous active-high reset
//   bus    sram_port_arbiter_if.slave (request/grant/response and SRAM pins)
// Parameters:
//   AW         SRAM word-address width
//   MAX_BURST  max consecutive grants to one port while the other requests (1..15)
// Build option:
//   SRAM_ARB_DPRIO_EN  when defined, load/store has fixed priority over fetch
module sram_port_arbiter #(
  parameter int AW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  sram_port_arbiter_if.slave   bus
);

  typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_e;

  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  port_e         last_q, last_d;
  port_e         rsp_port_q, rsp_port_d;
  logic [3:0]    bcnt_q, bcnt_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          gnt_i, gnt_d;
  port_e         gnt_port;
  logic [AW-1:0] sram_addr_d;

  always_comb begin
    gnt_i       = 1'b0;
    gnt_d       = 1'b0;
    gnt_port    = PORT_I;
    last_d      = last_q;
    bcnt_d      = bcnt_q;
    rsp_valid_d = 1'b0;
    rsp_port_d  = rsp_port_q;

    // Reset gates the grants combinationally so nothing reaches the macro while held.
    if (!rst_i) begin
      if (bus.i_req && bus.d_req) begin
`ifdef SRAM_ARB_DPRIO_EN
        gnt_d = 1'b1;
`else
        // bcnt_q == 0 means the previous cycle had no grant, so no burst is in
        // progress and the port opposite last wins (this makes I win right after reset).
        if ((bcnt_q != 4'd0) && (bcnt_q < MAX_BURST_C)) begin
          gnt_i = (last_q == PORT_I);
          gnt_d = (last_q == PORT_D);
        end else begin
          gnt_i = (last_q == PORT_D);
          gnt_d = (last_q == PORT_I);
        end
`endif
      end else begin
        gnt_i = bus.i_req;
        gnt_d = bus.d_req;
      end
    end

    if (gnt_d) begin
      gnt_port = PORT_D;
    end

    if (gnt_i || gnt_d) begin
      rsp_valid_d = 1'b1;
      rsp_port_d  = gnt_port;
      if (gnt_port == last_q) begin
        if (bcnt_q != 4'hF) begin
          bcnt_d = bcnt_q + 4'd1;
        end
      end else begin
        bcnt_d = 4'd1;
        last_d = gnt_port;
      end
    end else begin
      bcnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q      <= PORT_D;
      bcnt_q      <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= PORT_I;
    end else begin
      last_q      <= last_d;
      bcnt_q      <= bcnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_port_q  <= rsp_port_d;
    end
  end

  always_comb begin
    sram_addr_d = '0;
    if (gnt_d) begin
      sram_addr_d = bus.d_addr;
    end else if (gnt_i) begin
      sram_addr_d = bus.i_addr;
    end
  end

  assign bus.i_gnt      = gnt_i;
  assign bus.d_gnt      = gnt_d;
  assign bus.sram_cs    = gnt_i | gnt_d;
  assign bus.sram_addr  = sram_addr_d;
  assign bus.sram_wdata = gnt_d ? bus.d_wdata : 32'h0;
  assign bus.sram_wren  = (gnt_d && bus.d_we) ? bus.d_be : 4'b0000;

  assign bus.i_rvalid   = rsp_valid_q && (rsp_port_q == PORT_I);
  assign bus.d_rvalid   = rsp_valid_q && (rsp_port_q == PORT_D);
  assign bus.i_rdata    = bus.i_rvalid ? bus.sram_rdata : 32'h0;
  assign bus.d_rdata    = bus.d_rvalid ? bus.sram_rdata : 32'h0;

endmodule
